// File: rtl/rat_io_ctrl.sv
// rtl/rat_io_ctrl.sv - RAT MCU port-mapped I/O controller
// Output registers with readback, registered input ports and an edge-triggered masked IRQ unit.
module rat_io_ctrl #(
   parameter int          NUM_OUT       = 4,
   parameter logic [7:0]  OUT_BASE_ID   = 8'h40,
   parameter int          NUM_IN        = 4,
   parameter logic [7:0]  IN_BASE_ID    = 8'h20,
   parameter int          NUM_IRQ       = 4,
   parameter logic [7:0]  IRQ_MASK_ID   = 8'hF0,
   parameter logic [7:0]  IRQ_STATUS_ID = 8'hF1,
   parameter logic [7:0]  IRQ_CLR_ID    = 8'hF2,
   parameter int          SYNC_STAGES   = 2
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [7:0]             PORT_ID,
   input  logic [7:0]             OUT_PORT,
   input  logic                   IO_STRB,
   output logic [7:0]             IN_PORT,
   input  logic [NUM_IN*8-1:0]    IN_DATA,
   output logic [NUM_OUT*8-1:0]   OUT_DATA,
   input  logic [NUM_IRQ-1:0]     IRQ_SRC,
   output logic                   INTR
);

   function automatic bit ovl(input int a, input int na, input int b, input int nb);
      return (a < b + nb) && (b < a + na);
   endfunction

   localparam int OB = int'(OUT_BASE_ID);
   localparam int IB = int'(IN_BASE_ID);
   localparam int MI = int'(IRQ_MASK_ID);
   localparam int SI = int'(IRQ_STATUS_ID);
   localparam int CI = int'(IRQ_CLR_ID);

   localparam bit CFG_BAD =
      (NUM_OUT < 1) || (NUM_OUT > 16) || (NUM_IN < 1) || (NUM_IN > 16) ||
      (NUM_IRQ < 1) || (NUM_IRQ > 8) || (SYNC_STAGES < 2) ||
      (OB + NUM_OUT - 1 > 255) || (IB + NUM_IN - 1 > 255) ||
      ovl(OB, NUM_OUT, IB, NUM_IN) ||
      ovl(OB, NUM_OUT, MI, 1) || ovl(OB, NUM_OUT, SI, 1) || ovl(OB, NUM_OUT, CI, 1) ||
      ovl(IB, NUM_IN, MI, 1) || ovl(IB, NUM_IN, SI, 1) || ovl(IB, NUM_IN, CI, 1) ||
      (MI == SI) || (MI == CI) || (SI == CI);

   if (CFG_BAD) begin : g_cfg_err
      $error("rat_io_ctrl: invalid parameter set or overlapping port map");
   end

   logic [7:0]          out_q [NUM_OUT];
   logic [7:0]          out_d [NUM_OUT];
   logic [NUM_IN*8-1:0] in_q;
   logic [NUM_IRQ-1:0]  sync_q [SYNC_STAGES];
   logic [NUM_IRQ-1:0]  prev_q;
   logic [NUM_IRQ-1:0]  pending_q, pending_d;
   logic [NUM_IRQ-1:0]  mask_q, mask_d;
   logic [NUM_IRQ-1:0]  active, active_q;
   logic [NUM_IRQ-1:0]  rise, clr;
   logic                intr_q;
   logic [7:0]          out_off, in_off;
   logic [7:0]          rd_data;

   // Wrap-around subtract: IDs below a base land far outside the range.
   assign out_off = PORT_ID - OUT_BASE_ID;
   assign in_off  = PORT_ID - IN_BASE_ID;

   always_comb begin
      for (int i = 0; i < NUM_OUT; i++) out_d[i] = out_q[i];
      mask_d = mask_q;
      clr    = '0;
      if (IO_STRB) begin
         for (int i = 0; i < NUM_OUT; i++) begin
            if (out_off == 8'(i)) out_d[i] = OUT_PORT;
         end
         if (PORT_ID == IRQ_MASK_ID) mask_d = OUT_PORT[NUM_IRQ-1:0];
         if (PORT_ID == IRQ_CLR_ID)  clr    = OUT_PORT[NUM_IRQ-1:0];
      end
   end

   // A rise landing together with a clear keeps the bit set.
   assign rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign pending_d = (pending_q & ~clr) | rise;
   assign active    = pending_q & mask_q;

   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (in_off == 8'(i)) rd_data = in_q[8*i +: 8];
      end
      for (int i = 0; i < NUM_OUT; i++) begin
         if (out_off == 8'(i)) rd_data = out_q[i];
      end
      if (PORT_ID == IRQ_MASK_ID)   rd_data = 8'(mask_q);
      if (PORT_ID == IRQ_STATUS_ID) rd_data = 8'(pending_q);
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int i = 0; i < NUM_OUT; i++) out_q[i] <= '0;
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
         in_q      <= '0;
         prev_q    <= '0;
         pending_q <= '0;
         mask_q    <= '0;
         active_q  <= '0;
         intr_q    <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_OUT; i++) out_q[i] <= out_d[i];
         sync_q[0] <= IRQ_SRC;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
         in_q      <= IN_DATA;
         prev_q    <= sync_q[SYNC_STAGES-1];
         pending_q <= pending_d;
         mask_q    <= mask_d;
         active_q  <= active;
         intr_q    <= |(active & ~active_q);
      end
   end

   for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
      assign OUT_DATA[8*g +: 8] = out_q[g];
   end

   assign IN_PORT = rd_data;
   assign INTR    = intr_q;

endmodule
